// File: rtl/bmp_pixel_feeder.sv
// Pixel FIFO plus byte serializer that feeds encoder_bmp one BMP-ordered byte
// (B, G, R) per request, framing W*H pixels per frame_start_i pulse.
module bmp_pixel_feeder #(
  parameter logic [15:0] BMP_WIDTH  = 16'd8,
  parameter logic [15:0] BMP_HEIGHT = 16'd8,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                        sys_clk_i,
  input  logic                        sys_rst_i,
  input  logic                        frame_start_i,
  input  logic                        pix_valid_i,
  input  logic [23:0]                 pix_data_i,
  output logic                        pix_ready_o,
  input  logic                        src_data_req_i,
  output logic [7:0]                  src_data_o,
  output logic                        frame_done_o,
  output logic                        underflow_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] FRAME_PIX = 32'(BMP_WIDTH) * 32'(BMP_HEIGHT);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [23:0] mem [FIFO_DEPTH];
  logic [23:0] hold_q;
  logic [23:0] head;
  logic [1:0]  byte_idx;
  logic [31:0] in_cnt, out_cnt;

  logic active, full, empty, push, req, pop, last_byte;

  assign active = (state_q == ACTIVE);
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head   = mem[rd_ptr[AW-1:0]];

  assign pix_ready_o  = active && !full && (in_cnt < FRAME_PIX);
  assign busy_o       = active;
  assign fifo_level_o = wr_ptr - rd_ptr;

  // A start pulse overrides any push or request landing in the same cycle.
  assign push      = pix_valid_i && pix_ready_o && !frame_start_i;
  assign req       = active && src_data_req_i && !frame_start_i;
  assign pop       = req && (byte_idx == 2'd0) && !empty;
  assign last_byte = req && (byte_idx == 2'd2) && (out_cnt == FRAME_PIX - 32'd1);

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frame_start_i) state_d = ACTIVE;
      ACTIVE:  if (frame_start_i) state_d = ACTIVE;
               else if (last_byte) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the storage array has no reset; only the pointers define validity,
  // which keeps the array mappable onto RAM.
  always_ff @(posedge sys_clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= pix_data_i;
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      byte_idx     <= 2'd0;
      hold_q       <= '0;
      src_data_o   <= 8'h00;
      frame_done_o <= 1'b0;
      underflow_o  <= 1'b0;
    end else begin
      frame_done_o <= last_byte;
      if (frame_start_i) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        in_cnt      <= '0;
        out_cnt     <= '0;
        byte_idx    <= 2'd0;
        underflow_o <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          in_cnt <= in_cnt + 32'd1;
        end
        if (req) begin
          unique case (byte_idx)
            2'd0: begin
              // An empty slot is served as zeros so later bytes keep alignment.
              if (pop) begin
                hold_q     <= head;
                src_data_o <= head[7:0];
                rd_ptr     <= rd_ptr + 1'b1;
              end else begin
                hold_q      <= '0;
                src_data_o  <= 8'h00;
                underflow_o <= 1'b1;
              end
              byte_idx <= 2'd1;
            end
            2'd1: begin
              src_data_o <= hold_q[15:8];
              byte_idx   <= 2'd2;
            end
            default: begin
              src_data_o <= hold_q[23:16];
              byte_idx   <= 2'd0;
              out_cnt    <= out_cnt + 32'd1;
            end
          endcase
        end
        // Leftovers after an underflowed frame are discarded at frame end.
        if (last_byte) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end
      end
    end
  end

endmodule
